mac_pipe: RTL

Parametrised, fully pipelined fixed-point multiply-accumulate unit. It is the next-generation replacement for the single-cycle multiplier in the compute unit. It adds:
- a valid/stall handshake with the crossbar,
- a three-stage pipeline sustaining one operation per cycle,
- NUM_MR independent accumulator (MR) registers with per-operation selection,
- optional result saturation.

It sits between the register-file crossbar (operands xb_dtx/xb_dty) and the crossbar result bus, under program-sequencer control.

---
 rtl/mac_pkg.sv | 28 ++
 rtl/mac_fmt.sv | 85 ++++++++
 rtl/mac_pipe.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the mac_pipe multiply-accumulate unit.
//   - mac_cls_e     : operation class encoding carried on ps_mac_cls
//   - DTSTS_*       : bit positions inside ps_mac_dtsts
//   - acc_width()   : accumulator width A = 2W + guard bits
//   - mr_sel_width(): MR select width MS = max(1, clog2(NUM_MR))
package mac_pkg;

  typedef enum logic [1:0] {
    MAC_CLS_MR   = 2'b00,  // MR access: read (otreg=0) or clear (otreg=1)
    MAC_CLS_PROD = 2'b01,  // plain product
    MAC_CLS_ADD  = 2'b10,  // MR + product
    MAC_CLS_SUB  = 2'b11   // MR - product
  } mac_cls_e;

  localparam int DTSTS_RND  = 0;  // round to nearest (fractional only)
  localparam int DTSTS_FRAC = 1;  // fractional format
  localparam int DTSTS_XSGN = 2;  // Rx operand signed
  localparam int DTSTS_YSGN = 3;  // Ry operand signed

  function automatic int acc_width(input int w, input int guard);
    return 2 * w + guard;
  endfunction

  function automatic int mr_sel_width(input int num_mr);
    return (num_mr > 1) ? $clog2(num_mr) : 1;
  endfunction

endpackage

// File: rtl/mac_fmt.sv
// mac_fmt: combinational result formatter for the last mac_pipe stage.
// Rounds, extracts the W-bit result field, detects overflow / negative and
// optionally clamps the result.
// Ports:
//   r       in  A  raw accumulator-width result
//   frac    in  1  fractional format (field is r[2W-1:W], else r[W-1:0])
//   sgn     in  1  signed format (either operand signed)
//   rnd     in  1  round request (honoured only together with frac)
//   sat     in  1  clamp on overflow
//   flag_en in  1  0 forces mv/mn low (MR read-out reports no flags)
//   dt      out W  extracted (possibly clamped) result
//   r_wr    out A  value to store back into an MR (unrounded, possibly clamped)
//   mv, mn  out 1  overflow / negative
module mac_fmt
  import mac_pkg::*;
#(
  parameter int W = 16,
  parameter int A = 40
) (
  input  logic [A-1:0] r,
  input  logic         frac,
  input  logic         sgn,
  input  logic         rnd,
  input  logic         sat,
  input  logic         flag_en,
  output logic [W-1:0] dt,
  output logic [A-1:0] r_wr,
  output logic         mv,
  output logic         mn
);

  localparam logic [A-1:0] RND_INC = {{(A-W){1'b0}}, 1'b1, {(W-1){1'b0}}};

  logic [A-1:0] rr;
  logic [W-1:0] dt_raw;
  logic [W-1:0] dt_sat;
  logic [A-1:0] r_sat;
  logic         ovf;
  logic         do_sat;

  // Half an LSB of the fractional field gives round-to-nearest, ties up.
  assign rr = (rnd && frac) ? (r + RND_INC) : r;

  assign dt_raw = frac ? rr[2*W-1:W] : rr[W-1:0];

  // Overflow: the bits above the result field must be a pure extension
  // (all zero for unsigned, all copies of the field's sign bit for signed).
  always_comb begin
    ovf = 1'b0;
    if (frac) begin
      if (sgn) ovf = !((&rr[A-1:2*W-1]) || !(|rr[A-1:2*W-1]));
      else     ovf = |rr[A-1:2*W];
    end else begin
      if (sgn) ovf = !((&rr[A-1:W-1]) || !(|rr[A-1:W-1]));
      else     ovf = |rr[A-1:W];
    end
  end

  // Clamp values, expressed both as the W-bit field and as an A-bit MR image
  // positioned where the field lives in the chosen format.
  always_comb begin
    dt_sat = '1;
    r_sat  = '0;
    if (!sgn) begin
      dt_sat = '1;
      r_sat  = frac ? {{(A-2*W){1'b0}}, {(2*W){1'b1}}}
                    : {{(A-W){1'b0}}, {W{1'b1}}};
    end else if (!rr[A-1]) begin
      dt_sat = {1'b0, {(W-1){1'b1}}};
      r_sat  = frac ? {{(A-2*W+1){1'b0}}, {(2*W-1){1'b1}}}
                    : {{(A-W+1){1'b0}}, {(W-1){1'b1}}};
    end else begin
      dt_sat = {1'b1, {(W-1){1'b0}}};
      r_sat  = frac ? {{(A-2*W+1){1'b1}}, {(2*W-1){1'b0}}}
                    : {{(A-W+1){1'b1}}, {(W-1){1'b0}}};
    end
  end

  assign mv     = ovf & flag_en;
  assign mn     = sgn & rr[A-1] & flag_en;
  assign do_sat = sat & mv;
  assign dt     = do_sat ? dt_sat : dt_raw;
  assign r_wr   = do_sat ? r_sat : r;

endmodule

// File: rtl/mac_pipe.sv
// mac_pipe: pipelined fixed-point multiply-accumulate unit with NUM_MR
// accumulator registers. One operation per cycle, latency 3.
// Optional feature macro: MAC_SAT_EN (enables clamping when ps_mac_sat=1).
// Ports:
//   clk, reset           clock (rising edge) / async active-high reset
//   ps_mac_valid/ready   operation handshake from the program sequencer
//   ps_mac_cls/otreg     operation class / destination (see mac_cls_e)
//   ps_mac_mrsel         MR index
//   ps_mac_dtsts         [3] Ry signed [2] Rx signed [1] fractional [0] round
//   ps_mac_sat           saturate on overflow (MAC_SAT_EN builds only)
//   xb_dtx, xb_dty       operands from the crossbar
//   xb_stall             downstream busy: freezes the whole pipeline
//   mac_xb_dt/valid      result to the crossbar
//   mac_ps_mv/mn         overflow / negative, qualified by mac_xb_valid
//
// Handshake: an operation is accepted on a rising edge where
// ps_mac_valid=1 and ps_mac_ready=1. ps_mac_ready is simply ~xb_stall; while
// xb_stall=1 every stage register, the result outputs and all MRs hold, and
// a presented result is taken by the crossbar on an edge with
// mac_xb_valid=1 and xb_stall=0.
//
// Register stages (accept at edge k):
//   s1 (k)   : sign/zero-extended operands + control
//   s2 (k+1) : raw product truncated to 2W
//   s3 (k+2) : aligned product (fractional shift, sign-extended to A)
//   out(k+3) : MR read-modify-write, formatting, result registers
// The aligned product is registered so the accumulate path starts from flops.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int RF_DATASIZE = 16,
  parameter int ACC_GUARD   = 8,
  parameter int NUM_MR      = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ps_mac_valid,
  output logic                             ps_mac_ready,
  input  logic [1:0]                       ps_mac_cls,
  input  logic                             ps_mac_otreg,
  input  logic [mr_sel_width(NUM_MR)-1:0]  ps_mac_mrsel,
  input  logic [3:0]                       ps_mac_dtsts,
  input  logic                             ps_mac_sat,
  input  logic [RF_DATASIZE-1:0]           xb_dtx,
  input  logic [RF_DATASIZE-1:0]           xb_dty,
  input  logic                             xb_stall,
  output logic [RF_DATASIZE-1:0]           mac_xb_dt,
  output logic                             mac_xb_valid,
  output logic                             mac_ps_mv,
  output logic                             mac_ps_mn
);

  localparam int W  = RF_DATASIZE;
  localparam int A  = acc_width(RF_DATASIZE, ACC_GUARD);
  localparam int MS = mr_sel_width(NUM_MR);

`ifdef MAC_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  typedef struct packed {
    mac_cls_e      cls;
    logic          otreg;
    logic [MS-1:0] mrsel;
    logic [3:0]    dtsts;
    logic          sat;
  } ctl_t;

  logic adv;
  ctl_t ctl_in;

  logic                s1_valid, s2_valid, s3_valid;
  ctl_t                s1_ctl, s2_ctl, s3_ctl;
  logic signed [W:0]   s1_x, s1_y;
  logic signed [2*W-1:0] s2_prod;
  logic [A-1:0]        s3_p;
  logic [A-1:0]        mr_q [NUM_MR];

  logic signed [2*W-1:0] p_aligned;
  logic [A-1:0]        mr_rd;
  logic [A-1:0]        r;
  logic                mr_read;
  logic [W-1:0]        fmt_dt;
  logic [A-1:0]        fmt_r_wr;
  logic                fmt_mv, fmt_mn;

  assign adv          = ~xb_stall;
  assign ps_mac_ready = adv;

  always_comb begin
    ctl_in       = '0;
    ctl_in.cls   = mac_cls_e'(ps_mac_cls);
    ctl_in.otreg = ps_mac_otreg;
    ctl_in.mrsel = ps_mac_mrsel;
    ctl_in.dtsts = ps_mac_dtsts;
    ctl_in.sat   = ps_mac_sat;
  end

  // s1: operand extension to W+1 bits so one signed multiplier covers all
  // signed/unsigned combinations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_ctl   <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else if (adv) begin
      s1_valid <= ps_mac_valid;
      if (ps_mac_valid) begin
        s1_ctl <= ctl_in;
        s1_x   <= {ps_mac_dtsts[DTSTS_XSGN] & xb_dtx[W-1], xb_dtx};
        s1_y   <= {ps_mac_dtsts[DTSTS_YSGN] & xb_dty[W-1], xb_dty};
      end
    end
  end

  // s2: product modulo 2^(2W); sign-extending to 2W first keeps it exact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_ctl   <= '0;
      s2_prod  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ctl  <= s1_ctl;
        s2_prod <= (2*W)'(s1_x) * (2*W)'(s1_y);
      end
    end
  end

  // Signed fractional drops the redundant sign bit of the product.
  assign p_aligned = (s2_ctl.dtsts[DTSTS_FRAC] && s2_ctl.dtsts[DTSTS_XSGN] &&
                      s2_ctl.dtsts[DTSTS_YSGN]) ? (s2_prod <<< 1) : s2_prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_valid <= 1'b0;
      s3_ctl   <= '0;
      s3_p     <= '0;
    end else if (adv) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_ctl <= s2_ctl;
        s3_p   <= A'(p_aligned);
      end
    end
  end

  // MR read mux; an out-of-range index on non-power-of-two NUM_MR reads 0.
  always_comb begin
    mr_rd = '0;
    for (int i = 0; i < NUM_MR; i++) begin
      if (s3_ctl.mrsel == MS'(i)) mr_rd = mr_q[i];
    end
  end

  always_comb begin
    r = '0;
    case (s3_ctl.cls)
      MAC_CLS_PROD: r = s3_p;
      MAC_CLS_ADD:  r = mr_rd + s3_p;
      MAC_CLS_SUB:  r = mr_rd - s3_p;
      MAC_CLS_MR:   r = s3_ctl.otreg ? '0 : mr_rd;
    endcase
  end

  assign mr_read = (s3_ctl.cls == MAC_CLS_MR) && !s3_ctl.otreg;

  mac_fmt #(.W(W), .A(A)) u_fmt (
    .r       (r),
    .frac    (s3_ctl.dtsts[DTSTS_FRAC]),
    .sgn     (s3_ctl.dtsts[DTSTS_XSGN] | s3_ctl.dtsts[DTSTS_YSGN]),
    .rnd     (s3_ctl.dtsts[DTSTS_RND]),
    .sat     (s3_ctl.sat & SAT_EN),
    .flag_en (~mr_read),
    .dt      (fmt_dt),
    .r_wr    (fmt_r_wr),
    .mv      (fmt_mv),
    .mn      (fmt_mn)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mac_xb_valid <= 1'b0;
      mac_xb_dt    <= '0;
      mac_ps_mv    <= 1'b0;
      mac_ps_mn    <= 1'b0;
    end else if (adv) begin
      mac_xb_valid <= s3_valid;
      if (s3_valid) begin
        mac_xb_dt <= fmt_dt;
        mac_ps_mv <= fmt_mv;
        mac_ps_mn <= fmt_mn;
      end
    end
  end

  // otreg=1 writes MR[sel] for every class (cls=00 writes the cleared value).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_MR; i++) mr_q[i] <= '0;
    end else if (adv && s3_valid && s3_ctl.otreg) begin
      for (int i = 0; i < NUM_MR; i++) begin
        if (s3_ctl.mrsel == MS'(i)) mr_q[i] <= fmt_r_wr;
      end
    end
  end

endmodule
